// File: rtl/obf_key_loader.sv
// -----------------------------------------------------------------------------
// obf_key_loader
//
// Drives the 2-bit select codes {D_1,D_0} of NUM_GATES OBF-camouflaged gates.
// The key arrives one bit per cycle over a valid/ready handshake and is staged
// in a shadow register. A commit request checks the staged key and, if the
// check passes, copies it to key_bus in one step. Until that happens, key_bus
// carries DEFAULT_CODE on every gate pair. Once locked, the key cannot change
// again until reset.
//
// Per-gate code, with D_1 as the MSB:
//   00 true net, 01 CONST1, 10 inverted net, 11 CONST0
//
// Optional feature macro: KEY_PARITY_CHECK_EN
//   defined   : one extra serial bit carries even parity over the key, and
//               CHECK passes only if the XOR of all staged bits is 0
//   undefined : the key is exactly 2*NUM_GATES bits and CHECK always passes
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   key_sdi       in   serial key bit; gate 0 D_0 is sent first, then gate 0 D_1, ...
//   key_sdi_valid in   key_sdi is valid this cycle
//   key_sdi_ready out  loader accepts a bit this cycle (registered)
//   key_commit    in   one-cycle request to commit the staged key
//   key_bus       out  committed key; [2i+1:2i] = {D_1,D_0} of gate i
//   key_locked    out  key_bus holds a committed key
//   key_err       out  sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module obf_key_loader #(
    parameter int         NUM_GATES    = 1,
    parameter logic [1:0] DEFAULT_CODE = 2'b11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_sdi,
    input  logic                   key_sdi_valid,
    output logic                   key_sdi_ready,
    input  logic                   key_commit,
    output logic [2*NUM_GATES-1:0] key_bus,
    output logic                   key_locked,
    output logic                   key_err
);

    localparam int KW = 2 * NUM_GATES;
`ifdef KEY_PARITY_CHECK_EN
    localparam int KLEN = KW + 1;
`else
    localparam int KLEN = KW;
`endif
    localparam int CW = $clog2(2 * NUM_GATES + 2);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(KLEN - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        FULL   = 3'd2,
        CHECK  = 3'd3,
        LOCKED = 3'd4
    } state_t;

    // The staged key passes the check if the XOR over all staged bits is 0
    function automatic logic even_parity_ok(input logic [KLEN-1:0] bits);
        return ~(^bits);
    endfunction

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [KLEN-1:0]   shadow_q;
    logic [KW-1:0]     key_bus_q;
    logic              locked_q;
    logic              err_q;
    logic              ready_q;

    logic              xfer_s;
    logic [KLEN-1:0]   bit_vec_s;
    logic              check_ok_s;

    assign xfer_s = key_sdi_valid & ready_q;

    // Every position is written exactly once after the shadow register is
    // cleared, so OR-ing in a one-hot bit stores the incoming bit.
    assign bit_vec_s = {{(KLEN-1){1'b0}}, key_sdi} << cnt_q;

`ifdef KEY_PARITY_CHECK_EN
    assign check_ok_s = even_parity_ok(shadow_q);
`else
    assign check_ok_s = 1'b1;
`endif

    // Loader FSM; every output is a register updated together with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            key_bus_q <= {NUM_GATES{DEFAULT_CODE}};
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (key_commit) begin
                        // The error wins; a bit offered in the same cycle is dropped
                        err_q <= 1'b1;
                    end else if (xfer_s) begin
                        shadow_q <= shadow_q | bit_vec_s;
                        cnt_q    <= cnt_q + CNT_ONE;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (key_commit) begin
                        // Premature commit, including one that coincides with the
                        // final transfer: drop the partial key
                        err_q    <= 1'b1;
                        cnt_q    <= '0;
                        shadow_q <= '0;
                        state_q  <= IDLE;
                        ready_q  <= 1'b1;
                    end else if (xfer_s) begin
                        shadow_q <= shadow_q | bit_vec_s;
                        cnt_q    <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= FULL;
                            ready_q <= 1'b0;
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    ready_q <= 1'b0;
                    if (key_commit) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (check_ok_s) begin
                        key_bus_q <= shadow_q[KW-1:0];
                        locked_q  <= 1'b1;
                        state_q   <= LOCKED;
                        ready_q   <= 1'b0;
                    end else begin
                        err_q    <= 1'b1;
                        cnt_q    <= '0;
                        shadow_q <= '0;
                        state_q  <= IDLE;
                        ready_q  <= 1'b1;
                    end
                end
                LOCKED: begin
                    ready_q <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: fall back to the safe defaults
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    shadow_q  <= '0;
                    key_bus_q <= {NUM_GATES{DEFAULT_CODE}};
                    locked_q  <= 1'b0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign key_sdi_ready = ready_q;
    assign key_bus       = key_bus_q;
    assign key_locked    = locked_q;
    assign key_err       = err_q;

endmodule

// File: tb/tb_obf_key_loader.sv
// -----------------------------------------------------------------------------
// tb_obf_key_loader
//
// Directed bench for obf_key_loader. Two instances share one clock: u_dut1
// with NUM_GATES=1 and u_dut2 with NUM_GATES=2. Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge. When
// KEY_PARITY_CHECK_EN is defined, the bench appends the even-parity bit to
// each key.
// -----------------------------------------------------------------------------
module tb_obf_key_loader;

    logic       clk;
    logic       rst1_n, sdi1, v1, c1;
    logic       rst2_n, sdi2, v2, c2;
    logic       rdy1, lck1, err1;
    logic       rdy2, lck2, err2;
    logic [1:0] bus1;
    logic [3:0] bus2;

    int checks   = 0;
    int failures = 0;

    obf_key_loader #(.NUM_GATES(1), .DEFAULT_CODE(2'b11)) u_dut1 (
        .clk           (clk),
        .rst_n         (rst1_n),
        .key_sdi       (sdi1),
        .key_sdi_valid (v1),
        .key_sdi_ready (rdy1),
        .key_commit    (c1),
        .key_bus       (bus1),
        .key_locked    (lck1),
        .key_err       (err1)
    );

    obf_key_loader #(.NUM_GATES(2), .DEFAULT_CODE(2'b11)) u_dut2 (
        .clk           (clk),
        .rst_n         (rst2_n),
        .key_sdi       (sdi2),
        .key_sdi_valid (v2),
        .key_sdi_ready (rdy2),
        .key_commit    (c2),
        .key_bus       (bus2),
        .key_locked    (lck2),
        .key_err       (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare an observed value against the expected one and count the result
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All helpers are entered on a falling edge and return on a falling edge
    task automatic send1(input logic b);
        v1 = 1'b1; sdi1 = b;
        @(negedge clk);
        v1 = 1'b0; sdi1 = 1'b0;
    endtask

    task automatic send2(input logic b);
        v2 = 1'b1; sdi2 = b;
        @(negedge clk);
        v2 = 1'b0; sdi2 = 1'b0;
    endtask

    task automatic commit1();
        c1 = 1'b1;
        @(negedge clk);
        c1 = 1'b0;
    endtask

    task automatic commit2();
        c2 = 1'b1;
        @(negedge clk);
        c2 = 1'b0;
    endtask

    task automatic reset1();
        rst1_n = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic reset2();
        rst2_n = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst1_n = 1'b0; sdi1 = 1'b0; v1 = 1'b0; c1 = 1'b0;
        rst2_n = 1'b0; sdi2 = 1'b0; v2 = 1'b0; c2 = 1'b0;

        // ---- Defaults while held in reset, then ready after release ----
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_bus",    32'(bus1), 32'h3);
        check_eq("rst_locked", 32'(lck1), 32'h0);
        check_eq("rst_ready",  32'(rdy1), 32'h0);
        check_eq("rst_err",    32'(err1), 32'h0);
        check_eq("rst_bus2",   32'(bus2), 32'hF);
        rst1_n = 1'b1;
        @(negedge clk);
        check_eq("rel_ready",  32'(rdy1), 32'h1);

        // ---- Normal load: bits 0,1 -> 2'b10 ----
        send1(1'b0);
        check_eq("shift_ready", 32'(rdy1), 32'h1);
        send1(1'b1);
`ifdef KEY_PARITY_CHECK_EN
        send1(1'b1);
`endif
        check_eq("full_ready", 32'(rdy1), 32'h0);
        commit1();
        check_eq("check_bus_hold", 32'(bus1), 32'h3);
        check_eq("check_lck_hold", 32'(lck1), 32'h0);
        @(negedge clk);
        check_eq("load_bus",    32'(bus1), 32'h2);
        check_eq("load_locked", 32'(lck1), 32'h1);
        check_eq("load_err",    32'(err1), 32'h0);

        // ---- Lock stickiness: valid bits and commits are ignored ----
        for (int i = 0; i < 4; i++) begin
            v1 = 1'b1; sdi1 = i[0];
            @(negedge clk);
            check_eq("lock_ready", 32'(rdy1), 32'h0);
        end
        v1 = 1'b0;
        commit1();
        commit1();
        @(negedge clk);
        check_eq("lock_bus",    32'(bus1), 32'h2);
        check_eq("lock_err",    32'(err1), 32'h0);
        check_eq("lock_locked", 32'(lck1), 32'h1);

        // ---- Asynchronous reset mid-shift ----
        reset1();
        check_eq("rst2_bus", 32'(bus1), 32'h3);
        send1(1'b1);
        #2;
        rst1_n = 1'b0;
        #1;
        check_eq("async_bus",    32'(bus1), 32'h3);
        check_eq("async_locked", 32'(lck1), 32'h0);
        check_eq("async_ready",  32'(rdy1), 32'h0);
        @(negedge clk);
        rst1_n = 1'b1;
        @(negedge clk);
        send1(1'b1);
        send1(1'b0);
`ifdef KEY_PARITY_CHECK_EN
        send1(1'b1);
`endif
        commit1();
        @(negedge clk);
        check_eq("reload_bus",    32'(bus1), 32'h1);
        check_eq("reload_locked", 32'(lck1), 32'h1);

        // ---- Commit together with valid in IDLE: error wins, bit dropped ----
        reset1();
        v1 = 1'b1; sdi1 = 1'b1; c1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0; sdi1 = 1'b0; c1 = 1'b0;
        check_eq("idle_commit_err",   32'(err1), 32'h1);
        check_eq("idle_commit_ready", 32'(rdy1), 32'h1);
        send1(1'b0);
        send1(1'b1);
`ifdef KEY_PARITY_CHECK_EN
        send1(1'b1);
`endif
        commit1();
        @(negedge clk);
        check_eq("after_err_bus",    32'(bus1), 32'h2);
        check_eq("after_err_locked", 32'(lck1), 32'h1);
        check_eq("after_err_sticky", 32'(err1), 32'h1);

`ifdef KEY_PARITY_CHECK_EN
        // ---- Parity: good parity locks, bad parity errors ----
        reset1();
        send1(1'b1); send1(1'b0); send1(1'b1);
        commit1();
        @(negedge clk);
        check_eq("par_ok_bus", 32'(bus1), 32'h1);
        check_eq("par_ok_err", 32'(err1), 32'h0);
        reset1();
        send1(1'b1); send1(1'b0); send1(1'b0);
        commit1();
        @(negedge clk);
        check_eq("par_bad_err",    32'(err1), 32'h1);
        check_eq("par_bad_bus",    32'(bus1), 32'h3);
        check_eq("par_bad_locked", 32'(lck1), 32'h0);
        check_eq("par_bad_ready",  32'(rdy1), 32'h1);
`endif

        // ---- NUM_GATES=2: premature commit then full reload ----
        rst2_n = 1'b1;
        @(negedge clk);
        send2(1'b1); send2(1'b1); send2(1'b1);
        commit2();
        check_eq("prem_err",   32'(err2), 32'h1);
        check_eq("prem_bus",   32'(bus2), 32'hF);
        check_eq("prem_ready", 32'(rdy2), 32'h1);
        check_eq("prem_lck",   32'(lck2), 32'h0);
        send2(1'b0); send2(1'b0); send2(1'b1); send2(1'b0);
`ifdef KEY_PARITY_CHECK_EN
        send2(1'b1);
`endif
        commit2();
        @(negedge clk);
        check_eq("g2_bus",    32'(bus2), 32'h4);
        check_eq("g2_locked", 32'(lck2), 32'h1);
        check_eq("g2_err",    32'(err2), 32'h1);

        // ---- Commit in the same cycle as the final transfer ----
        reset2();
        send2(1'b0); send2(1'b1); send2(1'b1);
`ifdef KEY_PARITY_CHECK_EN
        send2(1'b0);
`endif
        v2 = 1'b1; sdi2 = 1'b1; c2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0; sdi2 = 1'b0; c2 = 1'b0;
        check_eq("last_commit_err",   32'(err2), 32'h1);
        check_eq("last_commit_ready", 32'(rdy2), 32'h1);
        commit2();
        @(negedge clk);
        check_eq("last_commit_bus", 32'(bus2), 32'hF);
        check_eq("last_commit_lck", 32'(lck2), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
